// File: rtl/instruction_loader.sv
// Instruction loader: assembles a framed UART byte stream (length, payload,
// XOR checksum) into little-endian 32-bit words for instruction memory.
module instruction_loader #(
    parameter int MEM_BYTES      = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] write_byte_address,
    output logic [31:0] write_instr_data,
    output logic        write_instr_valid,
    output logic        start,
    output logic        load_error,
    output logic        busy
);
    localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / 4);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEN   = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] CHECK = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ERROR = 3'd5;

    logic [2:0]    state;
    logic [1:0]    byte_cnt;
    logic [31:0]   shift_word;
    logic [31:0]   length;
    logic [31:0]   word_index;
    logic [7:0]    csum;
    logic [TW-1:0] timer;
    logic [31:0]   next_word;

    // Bytes arrive LSB first, so each new byte enters at the top.
    assign next_word = {rx_data, shift_word[31:8]};
    assign busy = (state == LEN) || (state == LOAD) || (state == CHECK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            byte_cnt           <= '0;
            shift_word         <= '0;
            length             <= '0;
            word_index         <= '0;
            csum               <= '0;
            timer              <= '0;
            write_byte_address <= '0;
            write_instr_data   <= '0;
            write_instr_valid  <= 1'b0;
            start              <= 1'b0;
            load_error         <= 1'b0;
        end else begin
            write_instr_valid <= 1'b0;
            if (busy) begin
                timer <= rx_valid ? '0 : timer + TW'(1);
            end
            unique case (state)
                IDLE: begin
                    if (rx_valid) begin
                        shift_word <= next_word;
                        byte_cnt   <= 2'd1;
                        state      <= LEN;
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        shift_word <= next_word;
                        byte_cnt   <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            length <= next_word;
                            if (next_word == '0 || next_word > MAX_WORDS) begin
                                state      <= ERROR;
                                load_error <= 1'b1;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (rx_valid) begin
                        shift_word <= next_word;
                        csum       <= csum ^ rx_data;
                        byte_cnt   <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            write_instr_valid  <= 1'b1;
                            write_instr_data   <= next_word;
                            write_byte_address <= {word_index[29:0], 2'b00};
                            word_index         <= word_index + 32'd1;
                            if (word_index == length - 32'd1) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            state <= DONE;
                            start <= 1'b1;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
            // A stalled sender abandons the frame.
            if (busy && !rx_valid && timer == TIMER_LAST) begin
                state      <= ERROR;
                load_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed frames plus random
// frames checked every cycle against a frame-position reference model.
module tb_instruction_loader;
    localparam int MEMB = 64;
    localparam int TMO  = 16;
    localparam int MAXW = MEMB / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [31:0] write_byte_address;
    logic [31:0] write_instr_data;
    logic        write_instr_valid;
    logic        start;
    logic        load_error;
    logic        busy;

    instruction_loader #(.MEM_BYTES(MEMB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .write_byte_address(write_byte_address),
        .write_instr_data(write_instr_data),
        .write_instr_valid(write_instr_valid),
        .start(start),
        .load_error(load_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: position of the next byte within the frame.
    int          m_pos;
    longint      m_len;
    int          m_idle;
    int          m_k;
    logic [7:0]  m_csum;
    logic [31:0] m_acc;
    bit          m_done;
    bit          m_err;
    bit          e_wv;
    logic [31:0] e_addr;
    logic [31:0] e_data;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos = 0; m_len = 0; m_idle = 0; m_csum = 0; m_acc = 0;
            m_done = 0; m_err = 0; e_wv = 0; e_addr = 0; e_data = 0;
        end else begin
            e_wv = 0;
            if (!m_done && !m_err) begin
                if (rx_valid) begin
                    m_idle = 0;
                    if (m_pos < 4) begin
                        m_len = m_len | (longint'(rx_data) << (8 * m_pos));
                        m_pos++;
                        if (m_pos == 4 && (m_len == 0 || m_len > MAXW)) m_err = 1;
                    end else if (m_pos < 4 + 4 * m_len) begin
                        m_k = m_pos - 4;
                        m_acc[8*(m_k%4) +: 8] = rx_data;
                        m_csum = m_csum ^ rx_data;
                        m_pos++;
                        if (m_k % 4 == 3) begin
                            e_wv = 1;
                            e_addr = 32'(4 * (m_k / 4));
                            e_data = m_acc;
                        end
                    end else if (rx_data == m_csum) begin
                        m_done = 1;
                    end else begin
                        m_err = 1;
                    end
                end else if (m_pos > 0) begin
                    m_idle++;
                    if (m_idle == TMO) m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_wvalid", 32'(write_instr_valid), 32'd0);
            chk("rst_addr", write_byte_address, 32'd0);
            chk("rst_data", write_instr_data, 32'd0);
            chk("rst_start", 32'(start), 32'd0);
            chk("rst_err", 32'(load_error), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end else begin
            chk("wvalid", 32'(write_instr_valid), 32'(e_wv));
            chk("addr", write_byte_address, e_addr);
            chk("data", write_instr_data, e_data);
            chk("start", 32'(start), 32'(m_done));
            chk("load_error", 32'(load_error), 32'(m_err));
            chk("busy", 32'(busy), 32'(m_pos > 0 && !m_done && !m_err));
            if (write_instr_valid) begin
                wq_addr.push_back(write_byte_address);
                wq_data.push_back(write_instr_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic send_len(input logic [31:0] n, input int gmax);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], $urandom_range(gmax, 0));
    endtask

    task automatic send_words(input logic [31:0] w[$], input int gmax,
                              output logic [7:0] cs);
        cs = 8'h00;
        foreach (w[i]) begin
            for (int j = 0; j < 4; j++) begin
                send_byte(w[i][8*j +: 8], $urandom_range(gmax, 0));
                cs = cs ^ w[i][8*j +: 8];
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[$];
        logic [7:0]  cs;
        int          n;
        bit          bad;

        // 1: two-word frame, good checksum (XOR of the eight payload bytes)
        do_reset();
        w = '{32'h00000013, 32'hFFC10113};
        send_len(32'd2, 2);
        send_words(w, 2, cs);
        chk("t1_csum_model", 32'(cs), 32'h3F);
        send_byte(8'h3F, 1);
        repeat (3) tick();
        chk("t1_nwr", 32'(wq_addr.size()), 32'd2);
        if (wq_addr.size() == 2) begin
            chk("t1_a0", wq_addr[0], 32'd0);
            chk("t1_d0", wq_data[0], 32'h00000013);
            chk("t1_a1", wq_addr[1], 32'd4);
            chk("t1_d1", wq_data[1], 32'hFFC10113);
        end
        chk("t1_start", 32'(start), 32'd1);
        chk("t1_err", 32'(load_error), 32'd0);

        // 2: same frame, wrong checksum
        do_reset();
        send_len(32'd2, 0);
        send_words(w, 0, cs);
        send_byte(8'h00, 0);
        repeat (3) tick();
        chk("t2_nwr", 32'(wq_addr.size()), 32'd2);
        chk("t2_err", 32'(load_error), 32'd1);
        chk("t2_start", 32'(start), 32'd0);

        // 3: illegal lengths
        do_reset();
        send_len(32'd0, 1);
        tick();
        chk("t3_zero_err", 32'(load_error), 32'd1);
        send_byte(8'h13, 0);
        do_reset();
        send_len(32'(MAXW + 1), 1);
        tick();
        chk("t3_big_err", 32'(load_error), 32'd1);
        do_reset();
        send_len(32'h00010001, 0);
        repeat (4) send_byte(8'hAA, 0);
        tick();
        chk("t3_hi_err", 32'(load_error), 32'd1);
        chk("t3_nwr", 32'(wq_addr.size()), 32'd0);

        // 4: back-to-back bytes, four words
        do_reset();
        w = '{};
        for (int i = 0; i < 4; i++) w.push_back($urandom);
        send_len(32'd4, 0);
        send_words(w, 0, cs);
        send_byte(cs, 0);
        repeat (2) tick();
        chk("t4_nwr", 32'(wq_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
            chk("t4_addr", wq_addr[i], 32'(4 * i));
            chk("t4_data", wq_data[i], w[i]);
        end
        chk("t4_start", 32'(start), 32'd1);

        // 5: sender stalls mid-word
        do_reset();
        send_len(32'd2, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), 0);
        repeat (TMO + 3) tick();
        chk("t5_nwr", 32'(wq_addr.size()), 32'd1);
        chk("t5_err", 32'(load_error), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_start", 32'(start), 32'd0);

        // 6: reset in the middle of LOAD, then a clean frame
        do_reset();
        send_len(32'd2, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 0);
        do_reset();
        w = '{32'h12345678, 32'h9ABCDEF0};
        send_len(32'd2, 1);
        send_words(w, 1, cs);
        send_byte(cs, 1);
        repeat (2) tick();
        chk("t6_nwr", 32'(wq_addr.size()), 32'd2);
        if (wq_addr.size() > 0) chk("t6_a0", wq_addr[0], 32'd0);
        chk("t6_start", 32'(start), 32'd1);

        // 7: random frames; the per-cycle compare does the checking
        for (int f = 0; f < 30; f++) begin
            do_reset();
            n = (f == 0) ? MAXW : $urandom_range(6, 1);
            bad = ($urandom_range(3, 0) == 0);
            w = '{};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            send_len(32'(n), 3);
            if (f % 6 == 5) begin
                for (int i = 0; i < $urandom_range(4 * n - 1, 0); i++)
                    send_byte(8'($urandom), $urandom_range(3, 0));
                repeat (TMO + 2) tick();
                chk("r_timeout_err", 32'(load_error), 32'd1);
            end else begin
                send_words(w, 3, cs);
                send_byte(bad ? (cs ^ 8'(1 << $urandom_range(7, 0))) : cs,
                          $urandom_range(3, 0));
                for (int i = 0; i < 3; i++) send_byte(8'($urandom), $urandom_range(2, 0));
                repeat (2) tick();
                chk("r_start", 32'(start), 32'(!bad));
                chk("r_nwr", 32'(wq_addr.size()), 32'(n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
